uart_cmd_assembler: RTL and testbench
=====================================

UART_CMD_ASSEMBLER -- requirements
Module: uart_cmd_assembler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 130200, max clk cycles allowed between high and low byte (5 byte times at 19200 baud, 50 MHz).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rx_rdy  input  1  byte-valid from UART receiver; level, stays high until cleared.
REQ-005 rx_data  input  8  received byte, valid while rx_rdy=1.
REQ-006 clr_rx_rdy  output  1  consume strobe to UART receiver; receiver drops rx_rdy on next edge.
REQ-007 clr_cmd_rdy  input  1  consumer acknowledge, clears cmd_rdy.
REQ-008 cmd  output  16  assembled command, {high byte, low byte}.
REQ-009 cmd_rdy  output  1  registered, high while an unacknowledged command is held in cmd.
REQ-010 timeout  output  1  registered one-cycle pulse, low byte not received in time.
REQ-011 overrun  output  1  registered sticky flag, a completed command overwrote an unacknowledged one.

Function
REQ-012 The FSM SHALL have two states: HIGH (await high byte) and LOW (await low byte); reset state HIGH.
REQ-013 In HIGH with rx_rdy=1: clr_rx_rdy=1 that cycle, rx_data captured into 8-bit high register, next state LOW, timeout counter loaded 0.
REQ-014 In LOW with rx_rdy=1: clr_rx_rdy=1 that cycle, cmd <= {high register, rx_data}, cmd_rdy <= 1, next state HIGH.
REQ-015 clr_rx_rdy SHALL be combinational, high only in cycles where a byte is consumed per REQ-013/014, never two consecutive cycles.
REQ-016 Latency: cmd and cmd_rdy valid on the edge immediately after the cycle the low byte is consumed (1 clk).
REQ-017 In LOW, counter SHALL increment each cycle rx_rdy=0; width ceil(log2(TIMEOUT_CYCLES)) bits, no wrap.
REQ-018 When counter = TIMEOUT_CYCLES-1 and rx_rdy=0: next state HIGH, high register discarded, timeout=1 next cycle for exactly one cycle, cmd/cmd_rdy unchanged.
REQ-019 rx_rdy=1 in the same cycle as counter terminal: byte wins, treated as low byte per REQ-014, no timeout.
REQ-020 clr_cmd_rdy=1 SHALL clear cmd_rdy and overrun on next edge; cmd retains its value.
REQ-021 Command completion while cmd_rdy=1 and clr_cmd_rdy=0: cmd overwritten, cmd_rdy stays 1, overrun <= 1.
REQ-022 Command completion and clr_cmd_rdy=1 in same cycle: cmd updated, cmd_rdy=1 (set wins), overrun <= 0.
REQ-023 cmd SHALL change only on command completion; stable otherwise, including during a new high-byte reception.
REQ-024 clr_cmd_rdy in HIGH or LOW SHALL not affect FSM state, high register, or counter.

Reset
REQ-025 On rst_n=0, immediately: state HIGH, cmd=16'h0000, cmd_rdy=0, timeout=0, overrun=0, high register=8'h00, counter=0.
REQ-026 Reset mid-command (in LOW) SHALL discard the partial byte; first byte after release is a high byte.
REQ-027 clr_rx_rdy SHALL be 0 while rst_n=0.

Verification
REQ-028 Bytes 8'hA5 then 8'h3C, each rx_rdy held until clr_rx_rdy -> one clr_rx_rdy pulse per byte, cmd=16'hA53C, cmd_rdy=1 one clk after second pulse.
REQ-029 High byte 8'h12, no further byte for TIMEOUT_CYCLES cycles -> timeout one-cycle pulse, state HIGH; then 8'h34, 8'h56 -> cmd=16'h3456.
REQ-030 Command 16'h1111 unacknowledged, then 16'h2222 -> cmd=16'h2222, cmd_rdy=1, overrun=1; clr_cmd_rdy pulse -> cmd_rdy=0, overrun=0, cmd=16'h2222.
REQ-031 clr_cmd_rdy asserted on the low-byte consume cycle of 16'hBEEF while prior command pending -> cmd=16'hBEEF, cmd_rdy=1, overrun=0.
REQ-032 Reset asserted after high byte 8'hFF, released, then 8'h01, 8'h02 -> cmd=16'h0102, no timeout pulse.
REQ-033 Low byte arriving exactly on counter terminal cycle -> command completes, timeout stays 0.

Source files
------------

// File: rtl/uart_cmd_assembler.sv
// Assembles two consecutive UART bytes {high, low} into a 16-bit command,
// with an inter-byte timeout, a consumer handshake and a sticky overrun flag.
module uart_cmd_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 130200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        timeout,
  output logic        overrun
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    ST_HIGH = 1'b0,
    ST_LOW  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       hi_q, hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             run_q;
  logic             consume;

  // run_q keeps the consume strobe low while reset is (or was just) asserted
  assign consume    = rx_rdy & run_q;
  assign clr_rx_rdy = consume;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q & ~clr_cmd_rdy;
    overrun_d = overrun_q & ~clr_cmd_rdy;
    timeout_d = 1'b0;
    case (state_q)
      ST_HIGH: begin
        if (consume) begin
          hi_d    = rx_data;
          cnt_d   = '0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (consume) begin
          // A byte on the terminal cycle still completes the command
          cmd_d     = {hi_q, rx_data};
          cmd_rdy_d = 1'b1;
          overrun_d = cmd_rdy_q & ~clr_cmd_rdy;
          state_d   = ST_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          hi_d      = '0;
          timeout_d = 1'b1;
          state_d   = ST_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_HIGH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HIGH;
      hi_q      <= '0;
      cnt_q     <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      run_q     <= 1'b1;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign timeout = timeout_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed self-checking bench for uart_cmd_assembler (short timeout).
module tb_uart_cmd_assembler;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        timeout;
  logic        overrun;

  int n_chk = 0;
  int n_err = 0;

  uart_cmd_assembler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .timeout     (timeout),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Receiver model: present a byte, expect it consumed in the same cycle, drop after the edge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    check("clr_rx_rdy_on", {15'b0, clr_rx_rdy}, 16'h0001);
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    #1;
    check("clr_rx_rdy_off", {15'b0, clr_rx_rdy}, 16'h0000);
  endtask

  task automatic ack();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    logic seen;
    rst_n       = 1'b0;
    rx_rdy      = 1'b1;
    rx_data     = 8'hEE;
    clr_cmd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clr_rx_rdy", {15'b0, clr_rx_rdy}, 16'h0000);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_cmd_rdy", {15'b0, cmd_rdy}, 16'h0000);
    check("rst_timeout", {15'b0, timeout}, 16'h0000);
    check("rst_overrun", {15'b0, overrun}, 16'h0000);
    rx_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic two-byte command
    send_byte(8'hA5);
    check("hi_cmd_rdy_low", {15'b0, cmd_rdy}, 16'h0000);
    check("hi_cmd_stable", cmd, 16'h0000);
    send_byte(8'h3C);
    check("basic_cmd", cmd, 16'hA53C);
    check("basic_cmd_rdy", {15'b0, cmd_rdy}, 16'h0001);
    check("basic_overrun", {15'b0, overrun}, 16'h0000);

    // Timeout after a lone high byte
    send_byte(8'h12);
    seen = 1'b0;
    for (int i = 1; i < int'(TO); i++) begin
      @(posedge clk);
      #1;
      if (timeout) seen = 1'b1;
    end
    check("to_early", {15'b0, seen}, 16'h0000);
    @(posedge clk);
    #1;
    check("to_pulse", {15'b0, timeout}, 16'h0001);
    check("to_cmd_kept", cmd, 16'hA53C);
    check("to_cmd_rdy_kept", {15'b0, cmd_rdy}, 16'h0001);
    @(posedge clk);
    #1;
    check("to_pulse_end", {15'b0, timeout}, 16'h0000);
    send_byte(8'h34);
    send_byte(8'h56);
    check("after_to_cmd", cmd, 16'h3456);
    check("after_to_overrun", {15'b0, overrun}, 16'h0001);
    ack();
    check("ack_cmd_rdy", {15'b0, cmd_rdy}, 16'h0000);
    check("ack_overrun", {15'b0, overrun}, 16'h0000);

    // Overrun
    send_byte(8'h11);
    send_byte(8'h11);
    check("ovr_first_rdy", {15'b0, cmd_rdy}, 16'h0001);
    check("ovr_first_flag", {15'b0, overrun}, 16'h0000);
    send_byte(8'h22);
    send_byte(8'h22);
    check("ovr_cmd", cmd, 16'h2222);
    check("ovr_rdy", {15'b0, cmd_rdy}, 16'h0001);
    check("ovr_flag", {15'b0, overrun}, 16'h0001);
    ack();
    check("ovr_ack_rdy", {15'b0, cmd_rdy}, 16'h0000);
    check("ovr_ack_flag", {15'b0, overrun}, 16'h0000);
    check("ovr_ack_cmd", cmd, 16'h2222);

    // Acknowledge during LOW must not disturb assembly
    send_byte(8'h5A);
    ack();
    check("ack_in_low_cmd", cmd, 16'h2222);
    send_byte(8'hC3);
    check("ack_in_low_done", cmd, 16'h5AC3);

    // Acknowledge coinciding with completion: set wins, overrun cleared
    send_byte(8'h77);
    send_byte(8'h88);
    check("pre_beef_flag", {15'b0, overrun}, 16'h0001);
    send_byte(8'hBE);
    @(negedge clk);
    rx_data     = 8'hEF;
    rx_rdy      = 1'b1;
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
    check("beef_cmd", cmd, 16'hBEEF);
    check("beef_rdy", {15'b0, cmd_rdy}, 16'h0001);
    check("beef_overrun", {15'b0, overrun}, 16'h0000);
    ack();

    // Low byte on the terminal counter cycle wins over timeout
    send_byte(8'h9A);
    repeat (TO - 1) @(posedge clk);
    send_byte(8'h7E);
    check("term_cmd", cmd, 16'h9A7E);
    check("term_timeout", {15'b0, timeout}, 16'h0000);
    @(posedge clk);
    #1;
    check("term_timeout_next", {15'b0, timeout}, 16'h0000);
    ack();

    // Reset mid-command discards the high byte
    send_byte(8'hFF);
    @(negedge clk);
    rst_n   = 1'b0;
    rx_data = 8'h55;
    rx_rdy  = 1'b1;
    #1;
    check("midrst_clr_rx_rdy", {15'b0, clr_rx_rdy}, 16'h0000);
    check("midrst_cmd", cmd, 16'h0000);
    check("midrst_cmd_rdy", {15'b0, cmd_rdy}, 16'h0000);
    @(negedge clk);
    rst_n  = 1'b1;
    rx_rdy = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    check("postrst_cmd", cmd, 16'h0102);
    seen = 1'b0;
    for (int i = 0; i < int'(TO) + 4; i++) begin
      @(posedge clk);
      #1;
      if (timeout) seen = 1'b1;
    end
    check("postrst_no_timeout", {15'b0, seen}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
